// File: rtl/sysid_check_master.sv
// sysid_check_master: reads sysid word 0 (ID) and word 1 (timestamp) over Avalon-MM and flags mismatches.
// Define SYSID_CHECK_AUTOSTART_EN to run the check once automatically after reset.
module sysid_check_master #(
   parameter int                ADDR_W         = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
   parameter logic [31:0]       EXPECTED_ID    = 32'd0,
   parameter logic [31:0]       EXPECTED_TS    = 32'd1671069002,
   parameter int                TIMEOUT_CYCLES = 1024
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_read,
   input  logic              avm_waitrequest,
   input  logic [31:0]       avm_readdata,
   input  logic              avm_readdatavalid,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              id_ok,
   output logic              ts_ok,
   output logic              timeout,
   output logic [31:0]       id_value,
   output logic [31:0]       ts_value
);
   typedef enum logic [2:0] {IDLE, RD_ID, WT_ID, RD_TS, WT_TS, FIN} state_t;
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [ADDR_W-1:0] TS_ADDR = BASE_ADDR + ADDR_W'(4);
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [ADDR_W-1:0] addr_n;
   logic read_n, busy_n, done_n, pass_n, id_ok_n, ts_ok_n, timeout_n, go;
   logic [31:0] id_value_n, ts_value_n;
`ifdef SYSID_CHECK_AUTOSTART_EN
   logic pend;
   always_ff @(posedge clock)
      pend <= !reset_n;
   assign go = start | pend;
`else
   assign go = start;
`endif
   always_comb begin
      state_n = state;
      cnt_n = (cnt == LIMIT) ? cnt : cnt + 1'b1;
      read_n = avm_read;
      addr_n = avm_address;
      done_n = done;
      pass_n = pass;
      id_ok_n = id_ok;
      ts_ok_n = ts_ok;
      timeout_n = timeout;
      id_value_n = id_value;
      ts_value_n = ts_value;
      case (state)
         IDLE: if (go) begin
            state_n = RD_ID;
            cnt_n = '0;
            read_n = 1'b1;
            addr_n = BASE_ADDR;
            done_n = 1'b0;
            pass_n = 1'b0;
            id_ok_n = 1'b0;
            ts_ok_n = 1'b0;
            timeout_n = 1'b0;
            id_value_n = '0;
            ts_value_n = '0;
         end
         RD_ID, RD_TS: if (!avm_waitrequest) begin
            state_n = (state == RD_ID) ? WT_ID : WT_TS;
            read_n = 1'b0;
         end else if (cnt == LIMIT) begin
            state_n = FIN;
            read_n = 1'b0;
            timeout_n = 1'b1;
         end
         WT_ID: if (avm_readdatavalid) begin
            id_value_n = avm_readdata;
            id_ok_n = avm_readdata == EXPECTED_ID;
            state_n = RD_TS;
            cnt_n = '0;
            read_n = 1'b1;
            addr_n = TS_ADDR;
         end else if (cnt == LIMIT) begin
            state_n = FIN;
            timeout_n = 1'b1;
         end
         WT_TS: if (avm_readdatavalid) begin
            ts_value_n = avm_readdata;
            ts_ok_n = avm_readdata == EXPECTED_TS;
            state_n = FIN;
         end else if (cnt == LIMIT) begin
            state_n = FIN;
            timeout_n = 1'b1;
         end
         default: state_n = IDLE;
      endcase
      // pass is latched together with done so it is valid the first cycle done is seen
      if (state != FIN && state_n == FIN) begin
         done_n = 1'b1;
         pass_n = id_ok_n & ts_ok_n & ~timeout_n;
      end
      busy_n = state_n != IDLE && state_n != FIN;
   end
   always_ff @(posedge clock)
      if (!reset_n) begin
         state <= IDLE;
         cnt <= '0;
         avm_read <= 1'b0;
         avm_address <= BASE_ADDR;
         busy <= 1'b0;
         done <= 1'b0;
         pass <= 1'b0;
         id_ok <= 1'b0;
         ts_ok <= 1'b0;
         timeout <= 1'b0;
         id_value <= '0;
         ts_value <= '0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         avm_read <= read_n;
         avm_address <= addr_n;
         busy <= busy_n;
         done <= done_n;
         pass <= pass_n;
         id_ok <= id_ok_n;
         ts_ok <= ts_ok_n;
         timeout <= timeout_n;
         id_value <= id_value_n;
         ts_value <= ts_value_n;
      end
endmodule

// File: tb/tb_sysid_check_master.sv
// tb_sysid_check_master: scoreboard bench for sysid_check_master with a behavioural Avalon slave.
module tb_sysid_check_master;
   localparam int T = 16;
   localparam logic [31:0] BASE = 32'h0000_0100;
   localparam logic [31:0] TS_A = 32'h0000_0104;
   localparam logic [31:0] EXP_ID = 32'd0;
   localparam logic [31:0] EXP_TS = 32'd1671069002;
   logic clock = 1'b0;
   logic reset_n, start, avm_read, avm_waitrequest, avm_readdatavalid;
   logic busy, done, pass, id_ok, ts_ok, timeout;
   logic [31:0] avm_address, avm_readdata, id_value, ts_value;
   int checks = 0, errors = 0;
   logic [68:0] res_q[$];
   logic [31:0] addr_q[$];
   int stall_cfg = 0, lat = 1;
   bit drop_ts = 1'b0;
   logic [31:0] id_word = EXP_ID, ts_word = EXP_TS;

   sysid_check_master #(.ADDR_W(32), .BASE_ADDR(BASE), .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS),
      .TIMEOUT_CYCLES(T)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .avm_address(avm_address), .avm_read(avm_read),
      .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
      .busy(busy), .done(done), .pass(pass), .id_ok(id_ok), .ts_ok(ts_ok), .timeout(timeout),
      .id_value(id_value), .ts_value(ts_value));

   always #5 clock = ~clock;

   function automatic logic [68:0] mk(input bit p, input bit io, input bit tk, input bit to,
                                      input logic [31:0] iv, input logic [31:0] tv);
      return {1'b1, p, io, tk, to, iv, tv};
   endfunction

   // slave: stalls stall_cfg cycles per read, answers lat cycles after acceptance
   initial begin
      int stall_left, rsp_cnt;
      bit in_req;
      logic [31:0] req_addr, rsp_data, exp_a;
      stall_left = 0; rsp_cnt = 0; in_req = 1'b0; req_addr = '0; rsp_data = '0;
      avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
      forever begin
         @(negedge clock); #2;
         avm_readdatavalid = 1'b0;
         if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
               avm_readdatavalid = 1'b1;
               avm_readdata = rsp_data;
            end
         end
         if (avm_read && reset_n) begin
            if (!in_req) begin
               in_req = 1'b1;
               req_addr = avm_address;
               stall_left = stall_cfg;
            end else begin
               checks++;
               if (avm_address !== req_addr) begin
                  errors++;
                  $display("FAIL addr_hold: got %h, required %h", avm_address, req_addr);
               end
            end
            if (stall_left > 0) begin
               avm_waitrequest = 1'b1;
               stall_left--;
            end else begin
               avm_waitrequest = 1'b0;
               in_req = 1'b0;
               checks++;
               if (addr_q.size() == 0) begin
                  errors++;
                  $display("FAIL read_addr: unexpected read at %h, none required", avm_address);
               end else begin
                  exp_a = addr_q.pop_front();
                  if (avm_address !== exp_a) begin
                     errors++;
                     $display("FAIL read_addr: got %h, required %h", avm_address, exp_a);
                  end
               end
               rsp_data = (avm_address == TS_A) ? ts_word : id_word;
               rsp_cnt = (drop_ts && avm_address == TS_A) ? 0 : lat;
            end
         end else begin
            avm_waitrequest = 1'b0;
            in_req = 1'b0;
         end
      end
   end

   // result scoreboard: one entry popped per rising edge of done
   initial begin
      logic done_q;
      logic [68:0] got, exp;
      done_q = 1'b0;
      forever begin
         @(negedge clock); #2;
         if (done && !done_q) begin
            got = {done, pass, id_ok, ts_ok, timeout, id_value, ts_value};
            checks++;
            if (res_q.size() == 0) begin
               errors++;
               $display("FAIL result: unexpected done, got %h", got);
            end else begin
               exp = res_q.pop_front();
               if (got !== exp) begin
                  errors++;
                  $display("FAIL result: got %h, required %h", got, exp);
               end
            end
         end
         done_q = done;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic pulse_start;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic wait_done(input int lim, output int n);
      n = 0;
      while (!done && n < lim) begin
         @(negedge clock);
         n++;
      end
   endtask

   task automatic test_reset;
      int n;
      reset_n = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clock);
      checks++;
      if ({busy, done, pass, id_ok, ts_ok, timeout, avm_read} !== 7'b0 || id_value !== 0 || ts_value !== 0 ||
          avm_address !== BASE) begin
         errors++;
         $display("FAIL reset_state: flags %b addr %h id %h ts %h, required 0 / %h",
                  {busy, done, pass, id_ok, ts_ok, timeout, avm_read}, avm_address, id_value, ts_value, BASE);
      end
`ifdef SYSID_CHECK_AUTOSTART_EN
      addr_q.push_back(BASE);
      addr_q.push_back(TS_A);
      res_q.push_back(mk(1, 1, 1, 0, EXP_ID, EXP_TS));
      reset_n = 1'b1;
      wait_done(20, n);
      checks++;
      if (!done || !pass) begin
         errors++;
         $display("FAIL autostart: done %b pass %b, required 1 1", done, pass);
      end
`else
      reset_n = 1'b1;
      repeat (3) @(negedge clock);
      checks++;
      if (busy || done || avm_read) begin
         errors++;
         $display("FAIL no_autostart: busy %b done %b read %b, required 0 0 0", busy, done, avm_read);
      end
`endif
      @(negedge clock);
   endtask

   task automatic test_match;
      int n;
      addr_q.push_back(BASE);
      addr_q.push_back(TS_A);
      res_q.push_back(mk(1, 1, 1, 0, EXP_ID, EXP_TS));
      pulse_start();
      checks++;
      if (!busy || !avm_read || avm_address !== BASE) begin
         errors++;
         $display("FAIL match_issue: busy %b read %b addr %h, required 1 1 %h", busy, avm_read, avm_address, BASE);
      end
      wait_done(10, n);
      checks++;
      if (!done || n + 1 > 6) begin
         errors++;
         $display("FAIL match_latency: done %b after %0d cycles, required 1 within 6", done, n + 1);
      end
      pulse_start();
      @(negedge clock);
      checks++;
      if (!done || busy || avm_read || !pass) begin
         errors++;
         $display("FAIL match_hold: done %b busy %b read %b pass %b, required 1 0 0 1", done, busy, avm_read, pass);
      end
   endtask

   task automatic test_id_mismatch;
      int n;
      id_word = 32'hDEAD_BEEF;
      addr_q.push_back(BASE);
      addr_q.push_back(TS_A);
      res_q.push_back(mk(0, 0, 1, 0, 32'hDEAD_BEEF, EXP_TS));
      pulse_start();
      wait_done(20, n);
      checks++;
      if (!done || pass || id_ok) begin
         errors++;
         $display("FAIL id_mismatch: done %b pass %b id_ok %b, required 1 0 0", done, pass, id_ok);
      end
      id_word = EXP_ID;
      @(negedge clock);
   endtask

   task automatic test_ts_mismatch;
      int n;
      ts_word = 32'd1671069003;
      addr_q.push_back(BASE);
      addr_q.push_back(TS_A);
      res_q.push_back(mk(0, 1, 0, 0, EXP_ID, 32'd1671069003));
      pulse_start();
      wait_done(20, n);
      checks++;
      if (!done || pass || ts_ok || !id_ok || ts_value !== 32'd1671069003) begin
         errors++;
         $display("FAIL ts_mismatch: done %b pass %b ts_ok %b id_ok %b ts %0d, required 1 0 0 1 1671069003",
                  done, pass, ts_ok, id_ok, ts_value);
      end
      ts_word = EXP_TS;
      @(negedge clock);
   endtask

   task automatic test_stall;
      int n;
      stall_cfg = 5;
      addr_q.push_back(BASE);
      addr_q.push_back(TS_A);
      res_q.push_back(mk(1, 1, 1, 0, EXP_ID, EXP_TS));
      pulse_start();
      @(negedge clock);
      pulse_start();
      wait_done(60, n);
      checks++;
      if (!done || !pass) begin
         errors++;
         $display("FAIL stall: done %b pass %b, required 1 1", done, pass);
      end
      stall_cfg = 0;
      @(negedge clock);
   endtask

   task automatic test_handshake_tie;
      int n;
      stall_cfg = T - 1;
      addr_q.push_back(BASE);
      addr_q.push_back(TS_A);
      res_q.push_back(mk(1, 1, 1, 0, EXP_ID, EXP_TS));
      pulse_start();
      wait_done(80, n);
      checks++;
      if (!done || !pass || timeout) begin
         errors++;
         $display("FAIL handshake_tie: done %b pass %b timeout %b, required 1 1 0", done, pass, timeout);
      end
      stall_cfg = 0;
      @(negedge clock);
   endtask

   task automatic test_rd_timeout;
      int n;
      stall_cfg = T;
      res_q.push_back(mk(0, 0, 0, 1, 32'd0, 32'd0));
      pulse_start();
      wait_done(40, n);
      checks++;
      if (!done || !timeout || avm_read || n > T) begin
         errors++;
         $display("FAIL rd_timeout: done %b timeout %b read %b after %0d cycles, required 1 1 0 within %0d",
                  done, timeout, avm_read, n, T);
      end
      stall_cfg = 0;
      @(negedge clock);
   endtask

   task automatic test_ts_timeout;
      int n, w;
      drop_ts = 1'b1;
      addr_q.push_back(BASE);
      addr_q.push_back(TS_A);
      res_q.push_back(mk(0, 1, 0, 1, EXP_ID, 32'd0));
      pulse_start();
      w = 0;
      while (!(avm_read && avm_address == TS_A) && w < 20) begin
         @(negedge clock);
         w++;
      end
      wait_done(40, n);
      checks++;
      if (!done || !timeout || pass || avm_read || n > T) begin
         errors++;
         $display("FAIL ts_timeout: done %b timeout %b pass %b read %b after %0d cycles, required 1 1 0 0 within %0d",
                  done, timeout, pass, avm_read, n, T);
      end
      drop_ts = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_reset_mid;
      int n;
      lat = 4;
      addr_q.push_back(BASE);
      pulse_start();
      @(negedge clock);
      reset_n = 1'b0;
      @(negedge clock);
      checks++;
      if ({busy, done, pass, id_ok, ts_ok, timeout, avm_read} !== 7'b0 || avm_address !== BASE) begin
         errors++;
         $display("FAIL reset_mid: flags %b addr %h, required 0 / %h",
                  {busy, done, pass, id_ok, ts_ok, timeout, avm_read}, avm_address, BASE);
      end
      @(negedge clock);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);
      checks++;
      if (id_value !== 0 || id_ok || busy || done) begin
         errors++;
         $display("FAIL late_data: id %h id_ok %b busy %b done %b, required 0 0 0 0", id_value, id_ok, busy, done);
      end
      lat = 1;
      addr_q.push_back(BASE);
      addr_q.push_back(TS_A);
      res_q.push_back(mk(1, 1, 1, 0, EXP_ID, EXP_TS));
      pulse_start();
      wait_done(20, n);
      checks++;
      if (!done || !pass) begin
         errors++;
         $display("FAIL after_reset: done %b pass %b, required 1 1", done, pass);
      end
      @(negedge clock);
   endtask

   initial begin
      reset_n = 1'b0;
      start = 1'b0;
      test_reset();
      test_match();
      test_id_mismatch();
      test_ts_mismatch();
      test_stall();
      test_handshake_tie();
      test_rd_timeout();
      test_ts_timeout();
      test_reset_mid();
      repeat (3) @(negedge clock);
      checks++;
      if (res_q.size() != 0 || addr_q.size() != 0) begin
         errors++;
         $display("FAIL leftover: %0d results and %0d reads outstanding, required 0 0", res_q.size(), addr_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/sysid_check_master.md
Name: sysid_check_master

Overview:
- Avalon-MM read master that polls the system ID peripheral during bring-up and checks it against the build-time expected values.
- Reads word 0 (system ID), then word 1 (timestamp), and compares each against parameters.
- Drives pass/fail status flags for LEDs or the host; catches a stale bitstream or software/hardware mismatch before the CPU boots.

Parameters:
- ADDR_W, 32, width of avm_address (byte address).
- BASE_ADDR, 0, byte base address of the sysid control slave.
- EXPECTED_ID, 0, expected value at word 0 (BASE_ADDR).
- EXPECTED_TS, 1671069002, expected value at word 1 (BASE_ADDR+4).
- TIMEOUT_CYCLES, 1024, maximum cycles per read phase before abort (minimum 2).

Ports:
- clock  in  1  single system clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to run a check; ignored while busy.
- avm_address  out  ADDR_W  byte address of the current read.
- avm_read  out  1  read request.
- avm_waitrequest  in  1  slave stall; the request is accepted on the first cycle with avm_read=1 and avm_waitrequest=0.
- avm_readdata  in  32  read data, qualified by avm_readdatavalid.
- avm_readdatavalid  in  1  read data valid.
- busy  out  1  check in progress.
- done  out  1  check finished; held until the next accepted start.
- pass  out  1  id_ok AND ts_ok AND NOT timeout; valid when done=1.
- id_ok  out  1  word 0 equalled EXPECTED_ID.
- ts_ok  out  1  word 1 equalled EXPECTED_TS.
- timeout  out  1  a read phase exceeded TIMEOUT_CYCLES.
- id_value  out  32  captured word 0.
- ts_value  out  32  captured word 1.

Behaviour:
- Reset (reset_n=0 at an edge), from any state including mid-read:
  - state=IDLE.
  - All outputs 0; avm_address=BASE_ADDR.
  - Timeout counter cleared.
  - Any in-flight response arriving after reset is ignored (readdatavalid is only sampled in WT states).
- FSM states: IDLE, RD_ID, WT_ID, RD_TS, WT_TS, FIN.
- IDLE:
  - start=1 -> RD_ID next cycle.
  - On that transition, clear done, pass, id_ok, ts_ok, timeout, id_value, ts_value.
- RD_ID:
  - avm_read=1, avm_address=BASE_ADDR, both held stable while avm_waitrequest=1.
  - Accepted -> WT_ID; avm_read drops the following cycle.
- WT_ID:
  - avm_read=0.
  - On avm_readdatavalid=1: id_value<=readdata, id_ok<=(readdata==EXPECTED_ID); go to RD_TS.
  - readdatavalid is never expected in the acceptance cycle (minimum read latency 1).
- RD_TS / WT_TS: identical to RD_ID / WT_ID with avm_address=BASE_ADDR+4; capture into ts_value/ts_ok; go to FIN.
- FIN: done=1, busy=0, pass registered from the flags; next state IDLE.
- busy=1 in every state other than IDLE and FIN; busy and done are registered outputs.
- done is set on entry to FIN and stays set in IDLE until the next accepted start.
- Timeout counter:
  - Cleared on entry to RD_ID and to RD_TS; increments every cycle in RD_x and WT_x; saturates.
  - When it reaches TIMEOUT_CYCLES-1 with no acceptance/valid in that cycle: timeout<=1, avm_read<=0, go to FIN.
  - An aborted read leaves the flags of the unread word at 0.
- Simultaneous events:
  - Acceptance or readdatavalid in the same cycle as the timeout limit: the handshake wins; no timeout.
  - start while busy or in FIN: ignored.
  - Spurious readdatavalid in IDLE, RD_x or FIN: ignored.
- Comparisons are full 32-bit unsigned equality. Address arithmetic BASE_ADDR+4 wraps modulo 2^ADDR_W.

Optional Feature:
- Macro: SYSID_CHECK_AUTOSTART_EN.
- Defined: an internal pending flag is set on reset and is treated as start on the first cycle after reset_n returns high; the check runs once with no external stimulus. The start port remains functional afterwards.
- Undefined: the check runs only on an external start pulse; no autostart logic is synthesized.

Test Plan:
- Match: start pulse; slave returns 0 then 1671069002, waitrequest=0, latency 1 -> done=1, pass=1, id_ok=1, ts_ok=1; done reached within 6 cycles of start.
- Stall: waitrequest=1 for 5 cycles on each read -> avm_read and avm_address held constant throughout; addresses issued are BASE_ADDR then BASE_ADDR+4; pass=1.
- Mismatch: timestamp returned as 1671069003 -> ts_ok=0, id_ok=1, pass=0, ts_value=1671069003.
- Timeout: TIMEOUT_CYCLES=16, readdatavalid never asserted on word 1 -> timeout=1, pass=0, avm_read=0, done within 16 cycles of entering RD_TS.
- Reset mid-read: reset_n low during WT_ID, late readdatavalid arrives after reset -> all outputs 0, state IDLE, late data not captured; a subsequent start passes.
- Autostart (macro defined): release reset with start tied 0 -> full check runs; done=1, pass=1.
